// File: rtl/ff_inv.sv
// ff_inv: modular inverse over the secp256k1 base field.
// Serial binary extended-Euclid datapath, one reduction step per clock.
// A run starts on reset release; tx_done rises once and holds until the next reset.
module ff_inv #(
    parameter logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] rx_a,
    output logic         tx_done,
    output logic [255:0] tx_a,
    output logic         tx_invalid
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [255:0] u_q, u_d;
    logic [255:0] v_q, v_d;
    logic [255:0] x1_q, x1_d;
    logic [255:0] x2_q, x2_d;
    logic [255:0] tx_a_q, tx_a_d;
    logic         invalid_q, invalid_d;

    // Halve x modulo P. An odd x is made even by adding P first; the sum
    // needs 257 bits so the carry survives into the shifted result.
    function automatic logic [255:0] half_mod(input logic [255:0] x);
        logic [256:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
        return s[256:1];
    endfunction

    // (a - b) mod P for a, b in [0, P). On borrow the wrapped difference
    // plus P, taken modulo 2^256, lands back in [0, P).
    function automatic logic [255:0] sub_mod(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[256] ? (d[255:0] + P) : d[255:0];
    endfunction

    // Operand reduction into [0, P): rx_a < 2^256 < 2P, so one conditional
    // subtraction suffices. A borrow means rx_a was already below P.
    logic [256:0] ar_diff;
    logic [255:0] ar;
    assign ar_diff = {1'b0, rx_a} - {1'b0, P};
    assign ar      = ar_diff[256] ? rx_a : ar_diff[255:0];

    logic u_is_one, v_is_one, u_ge_v;
    assign u_is_one = (u_q == 256'd1);
    assign v_is_one = (v_q == 256'd1);
    assign u_ge_v   = (u_q >= v_q);

    // Next-state and datapath: exactly one Euclid action per STEP cycle,
    // chosen by fixed priority; everything holds unless explicitly updated.
    always_comb begin
        state_d   = state_q;
        u_d       = u_q;
        v_d       = v_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        tx_a_d    = tx_a_q;
        invalid_d = invalid_q;
        case (state_q)
            S_LOAD: begin
                if (ar == 256'd0) begin
                    invalid_d = 1'b1;
                    tx_a_d    = 256'd0;
                    state_d   = S_DONE;
                end else begin
                    u_d     = ar;
                    v_d     = P;
                    x1_d    = 256'd1;
                    x2_d    = 256'd0;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (u_is_one) begin
                    tx_a_d  = x1_q;
                    state_d = S_DONE;
                end else if (v_is_one) begin
                    tx_a_d  = x2_q;
                    state_d = S_DONE;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_mod(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_mod(x2_q);
                end else if (u_ge_v) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run and re-arms LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_LOAD;
            u_q       <= 256'd0;
            v_q       <= 256'd0;
            x1_q      <= 256'd0;
            x2_q      <= 256'd0;
            tx_a_q    <= 256'd0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            u_q       <= u_d;
            v_q       <= v_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            tx_a_q    <= tx_a_d;
            invalid_q <= invalid_d;
        end
    end

    assign tx_done    = (state_q == S_DONE);
    assign tx_a       = tx_a_q;
    assign tx_invalid = invalid_q;

endmodule

// File: tb/tb_ff_inv.sv
// Directed testbench for ff_inv: known inverses, invalid operands,
// result hold, random operands checked by modular multiply, and async abort.
module tb_ff_inv;

    localparam logic [255:0] P    = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] INV2 = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;
    localparam int           MAX_LAT = 1026;

    logic         clk;
    logic         reset;
    logic [255:0] rx_a;
    logic         tx_done;
    logic [255:0] tx_a;
    logic         tx_invalid;

    int n_vec = 0;
    int n_err = 0;

    ff_inv dut (
        .clk        (clk),
        .reset      (reset),
        .rx_a       (rx_a),
        .tx_done    (tx_done),
        .tx_a       (tx_a),
        .tx_invalid (tx_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product modulo P using full-width arithmetic.
    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] prod;
        logic [511:0] r;
        prod = {256'd0, a} * {256'd0, b};
        r    = prod % {256'd0, P};
        return r[255:0];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Assert reset, present the operand, release between edges, then count
    // rising edges until tx_done (bounded).
    task automatic run(input logic [255:0] a, output int cyc);
        reset = 1'b1;
        rx_a  = a;
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        while (!tx_done && cyc < MAX_LAT + 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_inverse(input string tag, input logic [255:0] a, input int cyc);
        chk({tag, "_done"}, 256'(tx_done), 256'd1);
        chk({tag, "_lat"}, 256'(cyc <= MAX_LAT), 256'd1);
        chk({tag, "_valid"}, 256'(tx_invalid), 256'd0);
        chk({tag, "_range"}, 256'(tx_a < P), 256'd1);
        chk({tag, "_prod"}, mulmod(tx_a, a), 256'd1);
        $display("vector %s rx_a=%h tx_a=%h cycles=%0d", tag, a, tx_a, cyc);
    endtask

    initial begin
        int           cyc;
        logic [255:0] r;
        logic [255:0] held;

        reset = 1'b1;
        rx_a  = 256'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 256'(tx_done), 256'd0);
        chk("rst_tx_a", tx_a, 256'd0);
        chk("rst_invalid", 256'(tx_invalid), 256'd0);

        // rx_a = 1: inverse 1, fast path
        run(256'd1, cyc);
        chk("one_tx_a", tx_a, 256'd1);
        chk("one_lat3", 256'(cyc <= 3), 256'd1);
        check_inverse("one", 256'd1, cyc);

        // rx_a = 2: (P+1)/2
        run(256'd2, cyc);
        chk("two_tx_a", tx_a, INV2);
        check_inverse("two", 256'd2, cyc);

        // rx_a = P-1: self-inverse
        run(P - 256'd1, cyc);
        chk("pm1_tx_a", tx_a, P - 256'd1);
        check_inverse("pm1", P - 256'd1, cyc);

        // rx_a = P+1: reduces to 1 in LOAD
        run(P + 256'd1, cyc);
        chk("pp1_tx_a", tx_a, 256'd1);
        check_inverse("pp1", P + 256'd1, cyc);

        // Result holds while rx_a changes after completion
        held = tx_a;
        rx_a = 256'd12345;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", 256'(tx_done), 256'd1);
        chk("hold_tx_a", tx_a, held);
        $display("vector hold tx_a=%h", tx_a);

        // rx_a = 0 and rx_a = P: no inverse
        run(256'd0, cyc);
        chk("zero_done", 256'(tx_done), 256'd1);
        chk("zero_invalid", 256'(tx_invalid), 256'd1);
        chk("zero_tx_a", tx_a, 256'd0);
        chk("zero_lat", 256'(cyc <= 2), 256'd1);
        $display("vector zero invalid=%0b cycles=%0d", tx_invalid, cyc);

        run(P, cyc);
        chk("p_done", 256'(tx_done), 256'd1);
        chk("p_invalid", 256'(tx_invalid), 256'd1);
        chk("p_tx_a", tx_a, 256'd0);
        chk("p_lat", 256'(cyc <= 2), 256'd1);
        $display("vector p invalid=%0b cycles=%0d", tx_invalid, cyc);

        // Largest operand (reduces to 2^256-1-P)
        run({256{1'b1}}, cyc);
        check_inverse("max", {256{1'b1}}, cyc);

        // Small odd operand: 3 * ((2P+1)/3) = 2P+1 == 1
        run(256'd3, cyc);
        check_inverse("three", 256'd3, cyc);

        // Random operands
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
            run(r, cyc);
            check_inverse($sformatf("rand%0d", i), r, cyc);
        end

        // Abort mid-STEP: reset between edges clears outputs immediately
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        reset = 1'b1;
        rx_a  = r;
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_step_done", 256'(tx_done), 256'd0);
        chk("abort_step_tx_a", tx_a, 256'd0);
        $display("vector abort_step tx_done=%0b tx_a=%h", tx_done, tx_a);

        // New operand after abort produces its own inverse
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        run(r, cyc);
        check_inverse("after_abort", r, cyc);

        // Reset asserted in DONE clears a nonzero result immediately
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_done_done", 256'(tx_done), 256'd0);
        chk("abort_done_tx_a", tx_a, 256'd0);
        chk("abort_done_inv", 256'(tx_invalid), 256'd0);
        $display("vector abort_done tx_done=%0b tx_a=%h", tx_done, tx_a);

        run(256'd2, cyc);
        chk("rerun_two_tx_a", tx_a, INV2);
        check_inverse("rerun_two", 256'd2, cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
